// File: rtl/spike_inject_scheduler.sv
// spike_inject_scheduler
//   Shares the SNN descending-spike injection port between NUM_REQ requesters.
//   Granted neuron indices are OR-accumulated over one SNN tick. The accumulated
//   vector is released as a single-cycle inject pulse at the start of the next tick.
//   A per-tick grant budget applies, and while inhibit is high indices are
//   accepted and discarded (sleep mode).
//   Optional build macro: INJECT_PRIO_EN. When it is defined, requester 0 gets
//   strict priority and bypasses the budget.
module spike_inject_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_NEURONS  = 1024,
  parameter int IDX_W        = 10,
  parameter int TICK_CYCLES  = 300,
  parameter int MAX_PER_TICK = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     inhibit,
  output logic [NUM_NEURONS-1:0]   inject_spikes,
  output logic                     inject_valid,
  output logic [31:0]              accept_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int PW = $clog2(NUM_REQ);
  // The budget can run past MAX_PER_TICK when the priority requester bypasses it,
  // but it never exceeds one grant per cycle of the tick.
  localparam int BW = $clog2(TICK_CYCLES + MAX_PER_TICK + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BUDGET_MAX = BW'(MAX_PER_TICK);

  logic [TW-1:0]          tick_cnt;
  logic [PW-1:0]          rr_ptr;
  logic [BW-1:0]          budget;
  logic [NUM_NEURONS-1:0] accum;

  logic                   flush_phase;
  logic                   budget_ok;
  logic                   rr_hit;
  logic [PW-1:0]          rr_id;
  logic                   gnt_any;
  logic [PW-1:0]          gnt_id;
  logic                   gnt_moves_rr;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   in_range;
  logic                   do_accept;
  logic                   do_drop;
  logic [NUM_NEURONS-1:0] set_vec;

  assign flush_phase = (tick_cnt == TICK_LAST);
  // Under inhibit nothing reaches the SNN, so there is nothing to budget.
  assign budget_ok   = inhibit | (budget < BUDGET_MAX);

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_hit = 1'b0;
    rr_id  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!rr_hit && req_valid[(int'(rr_ptr) + off) % NUM_REQ]) begin
        rr_hit = 1'b1;
        rr_id  = PW'((int'(rr_ptr) + off) % NUM_REQ);
      end
    end
  end

  // Grant decision. A grant needs ACCUM and no reset. The budget gates every
  // requester except requester 0 when priority is enabled.
  always_comb begin
    gnt_any      = 1'b0;
    gnt_id       = '0;
    gnt_moves_rr = 1'b0;
    if (!rst && !flush_phase) begin
`ifdef INJECT_PRIO_EN
      if (req_valid[0]) begin
        gnt_any = 1'b1;
        gnt_id  = '0;
      end else if (budget_ok && rr_hit) begin
        gnt_any      = 1'b1;
        gnt_id       = rr_id;
        gnt_moves_rr = 1'b1;
      end
`else
      if (budget_ok && rr_hit) begin
        gnt_any      = 1'b1;
        gnt_id       = rr_id;
        gnt_moves_rr = 1'b1;
      end
`endif
    end
  end

  // One-hot ready; it is only raised for a requester whose valid is high.
  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  // Select the granted index and decode it into a one-hot set mask.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(gnt_id) == i) gnt_idx = req_idx[i*IDX_W +: IDX_W];
    end
    in_range  = ({{(32-IDX_W){1'b0}}, gnt_idx} < 32'(NUM_NEURONS));
    do_accept = gnt_any && !inhibit && in_range;
    do_drop   = gnt_any && (inhibit || !in_range);
    set_vec   = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      set_vec[n] = do_accept && (gnt_idx == IDX_W'(n));
    end
  end

  // Free-running tick counter, 0..TICK_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              tick_cnt <= '0;
    else if (flush_phase) tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + 1'b1;
  end

  // Release the accumulated vector on the FLUSH edge unless inhibited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inject_spikes <= '0;
      inject_valid  <= 1'b0;
    end else begin
      inject_valid <= flush_phase && !inhibit;
      if (flush_phase && !inhibit) inject_spikes <= accum;
    end
  end

  // Accumulator: cleared at every tick boundary and continuously while inhibited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        accum <= '0;
    else if (flush_phase || inhibit) accum <= '0;
    else                            accum <= accum | set_vec;
  end

  // Per-tick grant budget. Inhibited grants are not counted against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      budget <= '0;
    else if (flush_phase)         budget <= '0;
    else if (gnt_any && !inhibit) budget <= budget + 1'b1;
  end

  // Saturating accept/drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (do_accept && (accept_cnt != '1)) accept_cnt <= accept_cnt + 1'b1;
      if (do_drop && (drop_cnt != '1))     drop_cnt   <= drop_cnt + 1'b1;
    end
  end

  // Round-robin pointer moves past the winner. A priority grant leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               rr_ptr <= '0;
    else if (gnt_moves_rr) rr_ptr <= PW'((int'(gnt_id) + 1) % NUM_REQ);
  end

endmodule

// File: tb/tb_spike_inject_scheduler.sv
// Directed bench for spike_inject_scheduler (NUM_REQ=4, TICK_CYCLES=8,
// MAX_PER_TICK=4, NUM_NEURONS=1000). Inputs change on the falling edge, and
// outputs are sampled 1 ns later. tc is the bench's own copy of the tick phase.
module tb_spike_inject_scheduler;

  localparam int NR = 4;
  localparam int NN = 1000;
  localparam int IW = 10;
  localparam int TC = 8;
  localparam int MP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*IW-1:0] req_idx;
  logic [NR-1:0]    req_ready;
  logic             inhibit;
  logic [NN-1:0]    inject_spikes;
  logic             inject_valid;
  logic [31:0]      accept_cnt;
  logic [15:0]      drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int tc       = 0;

  spike_inject_scheduler #(
    .NUM_REQ(NR), .NUM_NEURONS(NN), .IDX_W(IW), .TICK_CYCLES(TC), .MAX_PER_TICK(MP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .inhibit(inhibit), .inject_spikes(inject_spikes),
    .inject_valid(inject_valid), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idx(input int r, input int v);
    req_idx[r*IW +: IW] = IW'(v);
  endtask

  // Drive valids for the current cycle, check ready, then advance one clock.
  task automatic run_cycle(input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy);
    req_valid = v;
    #1;
    check_val($sformatf("ready tc=%0d", tc), 1024'(req_ready), 1024'(exp_rdy));
    if (tc != 0) check_val($sformatf("iv_low tc=%0d", tc), 1024'(inject_valid), 1024'(0));
    @(posedge clk);
    @(negedge clk);
    tc = (tc + 1) % TC;
  endtask

  // Checks at tick_cnt==0, before this cycle's inputs are applied.
  task automatic tick_start(input string tag, input logic iv, input logic [NN-1:0] vec,
                            input int acc, input int drp);
    #1;
    check_val({tag, " tc0"},    1024'(tc), 1024'(0));
    check_val({tag, " iv"},     1024'(inject_valid), 1024'(iv));
    check_val({tag, " spikes"}, 1024'(inject_spikes), 1024'(vec));
    check_val({tag, " acc"},    1024'(accept_cnt), 1024'(acc));
    check_val({tag, " drop"},   1024'(drop_cnt), 1024'(drp));
  endtask

  logic [NN-1:0] ev;
  logic [NN-1:0] v_basic;
  logic [NR-1:0] rdy_tbl [TC];
  int            acc_exp;

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_idx   = '0;
    inhibit   = 1'b0;

    // Reset held for three cycles with every requester valid.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("rst ready",  1024'(req_ready), 1024'(0));
      check_val("rst iv",     1024'(inject_valid), 1024'(0));
      check_val("rst acc",    1024'(accept_cnt), 1024'(0));
      check_val("rst drop",   1024'(drop_cnt), 1024'(0));
      check_val("rst spikes", 1024'(inject_spikes), 1024'(0));
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    tc        = 0;

    // Tick 0: basic accumulation (req0 idx 5, req2 idx 700).
    tick_start("t0", 1'b0, '0, 0, 0);
    set_idx(0, 5);
    set_idx(2, 700);
    run_cycle(4'b0101, 4'b0001);
    run_cycle(4'b0100, 4'b0100);
    for (int t = 2; t < TC; t++) run_cycle(4'b0000, 4'b0000);

    // Tick 1: inject {5,700}. Accumulate 3 and 9, then raise inhibit at tc=4.
    v_basic = '0;
    v_basic[5]   = 1'b1;
    v_basic[700] = 1'b1;
    tick_start("t1", 1'b1, v_basic, 2, 0);
    set_idx(0, 3);
    set_idx(1, 9);
    set_idx(2, 20);
    set_idx(3, 21);
    run_cycle(4'b0001, 4'b0001);
    run_cycle(4'b0010, 4'b0010);
    run_cycle(4'b0000, 4'b0000);
    run_cycle(4'b0000, 4'b0000);
    inhibit = 1'b1;
    run_cycle(4'b0000, 4'b0000);
    run_cycle(4'b0100, 4'b0100);
    run_cycle(4'b1000, 4'b1000);
    #1;
    check_val("inh drop", 1024'(drop_cnt), 1024'(2));
    run_cycle(4'b0000, 4'b0000);

    // Tick 2: no pulse and spikes unchanged. Drop inhibit, then grant req0 idx 7.
    tick_start("t2", 1'b0, v_basic, 4, 2);
    inhibit = 1'b0;
    set_idx(0, 7);
    run_cycle(4'b0000, 4'b0000);
    run_cycle(4'b0001, 4'b0001);
    for (int t = 2; t < TC; t++) run_cycle(4'b0000, 4'b0000);

    // Tick 3: all requesters valid continuously (budget / priority).
    ev = '0;
    ev[7] = 1'b1;
    tick_start("t3", 1'b1, ev, 5, 2);
    for (int r = 0; r < NR; r++) set_idx(r, 10 + r);
`ifdef INJECT_PRIO_EN
    for (int t = 0; t < TC; t++) rdy_tbl[t] = (t < TC - 1) ? 4'b0001 : 4'b0000;
    acc_exp = 5 + 7;
    ev = '0;
    ev[10] = 1'b1;
`else
    rdy_tbl[0] = 4'b0010; rdy_tbl[1] = 4'b0100; rdy_tbl[2] = 4'b1000; rdy_tbl[3] = 4'b0001;
    for (int t = 4; t < TC; t++) rdy_tbl[t] = 4'b0000;
    acc_exp = 5 + 4;
    ev = '0;
    for (int b = 10; b < 14; b++) ev[b] = 1'b1;
`endif
    for (int t = 0; t < TC; t++) run_cycle(4'b1111, rdy_tbl[t]);

    // Tick 4: req0 (idx 30) and req1 (idx 31) continuously valid.
    tick_start("t4", 1'b1, ev, acc_exp, 2);
    set_idx(0, 30);
    set_idx(1, 31);
    ev = '0;
    ev[30] = 1'b1;
`ifdef INJECT_PRIO_EN
    acc_exp = acc_exp + 7;
`else
    rdy_tbl[0] = 4'b0010; rdy_tbl[1] = 4'b0001; rdy_tbl[2] = 4'b0010; rdy_tbl[3] = 4'b0001;
    acc_exp = acc_exp + 4;
    ev[31] = 1'b1;
`endif
    for (int t = 0; t < TC; t++) run_cycle(4'b0011, rdy_tbl[t]);

    // Tick 5: inject the tick-4 vector. Present req1 idx 1023 in FLUSH.
    tick_start("t5", 1'b1, ev, acc_exp, 2);
    set_idx(1, 1023);
    for (int t = 0; t < TC - 1; t++) run_cycle(4'b0000, 4'b0000);
    run_cycle(4'b0010, 4'b0000);

    // Tick 6: the held request is granted at tc=0. It is out of range, so it is dropped.
    tick_start("t6", 1'b1, '0, acc_exp, 2);
    run_cycle(4'b0010, 4'b0010);
    #1;
    check_val("range drop", 1024'(drop_cnt), 1024'(3));
    check_val("range acc",  1024'(accept_cnt), 1024'(acc_exp));
    for (int t = 1; t < TC; t++) run_cycle(4'b0000, 4'b0000);

    // Tick 7: the dropped index leaves no bit set.
    tick_start("t7", 1'b1, '0, acc_exp, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
